q_measure_seq: RTL and testbench
================================

# q_measure_seq

Measurement responder for the bisection current-control loop. It accepts a current reference `i_ref` from the bisection controller and loads it into the DAC. After a programmable settling delay it runs one or more ADC conversions of the resulting Q, then returns `meas_q` with a one-cycle valid pulse. This closes the loop that the bisection block opens.

## Interface
- `WIDTH`, 10: width of `i_ref`, DAC code, ADC data and `meas_q`.
- `SETTLE_CYCLES`, 16: idle cycles between DAC load and the first ADC start; 0 allowed.
- `AVG_LOG2`, 2: log2 of samples averaged per request; used only when `Q_AVG_EN` is defined.
- `TIMEOUT`, 255: maximum cycles spent waiting in WAIT for `adc_done`; must be at least 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request from the bisection controller.
- `req_ready`  out  1  high only in IDLE.
- `i_ref`  in  WIDTH  requested current code; sampled on handshake.
- `dac_code`  out  WIDTH  registered DAC code.
- `dac_load`  out  1  one-cycle DAC latch strobe.
- `adc_start`  out  1  one-cycle conversion start.
- `adc_done`  in  1  conversion complete; qualifies `adc_data`.
- `adc_data`  in  WIDTH  conversion result.
- `meas_valid`  out  1  one-cycle result strobe.
- `meas_q`  out  WIDTH  measured Q; holds until the next DONE.
- `meas_timeout`  out  1  flag for the current result; updated in DONE.

## Operation
- Reset values: state IDLE; `req_ready`=1; every other output is 0; accumulator and all counters are 0.
- States and transitions:
  - IDLE: `req_valid & req_ready` latches `i_ref` into `dac_code`, clears the accumulator, sample count and timeout count, then moves to LOAD.
  - LOAD: `dac_load`=1. Moves to SETTLE, or straight to START if `SETTLE_CYCLES`=0.
  - SETTLE: counts `SETTLE_CYCLES` cycles, then moves to START.
  - START: `adc_start`=1 for this cycle; clears the timeout count; moves to WAIT.
  - WAIT:
    - On `adc_done`: accumulator += `adc_data`; sample count increments. If this was the last sample, move to DONE; otherwise move to START.
    - Without `adc_done`: the timeout count increments. On reaching `TIMEOUT`, move to DONE with the timeout flag set.
  - DONE: `meas_valid`=1. `meas_q` = accumulator >> `AVG_LOG2` (truncating), or 0 on timeout. `meas_timeout` takes the flag. Moves to IDLE.
- The accumulator is `WIDTH+AVG_LOG2` bits wide and never overflows; full-scale input averages to full scale.
- `adc_done` is ignored in every state except WAIT.
- `req_valid` is ignored while busy. No queueing: the requester must hold `req_valid` until `req_ready` is high.
- Asynchronous reset mid-operation aborts immediately to IDLE with reset values. No `meas_valid` is issued for the aborted request.

## Timing
- Cycle numbering: cycle 0 is the handshake cycle; `dac_code` is updated at the end of cycle 0.
- Cycle 1: `dac_load`=1.
- Cycles 2..S+1: SETTLE, where S=`SETTLE_CYCLES`.
- Each sample needs at least 2 cycles: START, then WAIT with `adc_done` high.
- Minimum latency: `meas_valid` in cycle S+2+2N, where N is the number of samples.
  - Default build: 26.
  - S=0, N=1: 4.
- Each extra WAIT cycle per sample adds 1 to the latency.
- Timeout path: DONE follows WAIT by `TIMEOUT` cycles without `adc_done`; the remaining samples are abandoned.
- `req_ready` returns high in the cycle after DONE. Back-to-back throughput is therefore one request per S+3+2N cycles minimum.

## Configuration
- `Q_AVG_EN` defined: N = 2**`AVG_LOG2` samples per request; `meas_q` is their truncated mean.
- `Q_AVG_EN` undefined:
  - N = 1; `AVG_LOG2` is ignored and treated as 0.
  - The accumulator is `WIDTH` bits wide.
  - `meas_q` = the single `adc_data` sample.

## Test plan
- Single sample (macro off, S=16): `i_ref`=512, ADC returns 300 one cycle after `adc_start` -> `dac_code`=512, `dac_load` in cycle 1, `adc_start` in cycle 18, `meas_valid` in cycle 20 with `meas_q`=300 and `meas_timeout`=0.
- Averaging (macro on, AVG_LOG2=2):
  - Samples 100, 101, 102, 103 -> `meas_q`=101 in cycle 26.
  - Four samples of 1023 -> `meas_q`=1023, no wrap.
- Timeout (TIMEOUT=8): `adc_done` never asserted -> `meas_valid` 8 cycles after entering WAIT, `meas_q`=0, `meas_timeout`=1. The next good request clears `meas_timeout`.
- Busy request: second `req_valid` with `i_ref`=7 during SETTLE -> `req_ready`=0, `dac_code` unchanged, exactly one `meas_valid`. The held request is accepted in the cycle after DONE.
- Reset mid-SETTLE: `rst_n` low -> all outputs 0 immediately, `req_ready`=1 after release, no `meas_valid`; a new request completes normally.
- Stray `adc_done`: `adc_done` pulsed during SETTLE and during START -> accumulator unchanged, result equals the WAIT-sampled data only.

Source files
------------

// File: rtl/q_measure_seq_if.sv
// Measurement bus between the bisection controller/ADC/DAC and q_measure_seq.
// Carries the request handshake, DAC latch, ADC conversion handshake and result strobe.
// Modports: master = controller + analog front-end side, slave = q_measure_seq.
interface q_measure_seq_if #(
    parameter int WIDTH = 10
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] i_ref;
    logic [WIDTH-1:0] dac_code;
    logic             dac_load;
    logic             adc_start;
    logic             adc_done;
    logic [WIDTH-1:0] adc_data;
    logic             meas_valid;
    logic [WIDTH-1:0] meas_q;
    logic             meas_timeout;

    modport master (
        output req_valid, i_ref, adc_done, adc_data,
        input  req_ready, dac_code, dac_load, adc_start, meas_valid, meas_q, meas_timeout
    );

    modport slave (
        input  req_valid, i_ref, adc_done, adc_data,
        output req_ready, dac_code, dac_load, adc_start, meas_valid, meas_q, meas_timeout
    );
endinterface

// File: rtl/q_measure_seq.sv
// Purpose: load i_ref into the DAC, wait SETTLE_CYCLES, run ADC conversion(s), return meas_q.
// Latency: meas_valid in cycle S+2+2N after the handshake (more if the ADC is slow or times out).
// Backpressure: req_ready only in IDLE; requests are not queued, requester holds req_valid.
//
// Ports: clk, rst_n (async active-low), bus (q_measure_seq_if.slave): request handshake
// (req_valid/req_ready/i_ref), DAC (dac_code/dac_load), ADC (adc_start/adc_done/adc_data),
// result (meas_valid/meas_q/meas_timeout).
// Build option: define Q_AVG_EN to average 2**AVG_LOG2 samples per request; otherwise one sample.
module q_measure_seq #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    q_measure_seq_if.slave       bus
);

`ifdef Q_AVG_EN
    localparam int AVG_SH = AVG_LOG2;
`else
    // Single-sample build: no averaging shift, accumulator is just WIDTH bits.
    localparam int AVG_SH = AVG_LOG2 - AVG_LOG2;
`endif
    localparam int ACC_W    = WIDTH + AVG_SH;
    localparam int NSAMP    = 1 << AVG_SH;
    localparam int SMP_W    = AVG_SH + 1;
    localparam int SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SET_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dac_code_q, dac_code_d;
    logic [WIDTH-1:0]   meas_q_q, meas_q_d;
    logic               meas_to_q, meas_to_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [TO_W-1:0]    to_q, to_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dac_code_q <= '0;
            meas_q_q   <= '0;
            meas_to_q  <= 1'b0;
            acc_q      <= '0;
            smp_q      <= '0;
            set_q      <= '0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            dac_code_q <= dac_code_d;
            meas_q_q   <= meas_q_d;
            meas_to_q  <= meas_to_d;
            acc_q      <= acc_d;
            smp_q      <= smp_d;
            set_q      <= set_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dac_code_d = dac_code_q;
        meas_q_d   = meas_q_q;
        meas_to_d  = meas_to_q;
        acc_d      = acc_q;
        smp_d      = smp_q;
        set_d      = set_q;
        to_d       = to_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    dac_code_d = bus.i_ref;
                    acc_d      = '0;
                    smp_d      = '0;
                    to_d       = '0;
                    set_d      = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                set_d   = '0;
                state_d = (SETTLE_CYCLES == 0) ? S_START : S_SETTLE;
            end
            S_SETTLE: begin
                if (set_q == SET_W'(SET_LAST)) begin
                    state_d = S_START;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.adc_done) begin
                    acc_d = acc_q + ACC_W'(bus.adc_data);
                    smp_d = smp_q + 1'b1;
                    if (smp_q == SMP_W'(NSAMP - 1)) begin
                        // Result is registered on entry to DONE so it is already
                        // stable while meas_valid is high.
                        meas_q_d  = WIDTH'(acc_d >> AVG_SH);
                        meas_to_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end else begin
                    to_d = to_q + 1'b1;
                    if (to_d == TO_W'(TIMEOUT)) begin
                        // Remaining samples are abandoned; report a zero result.
                        meas_q_d  = '0;
                        meas_to_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.dac_load     = (state_q == S_LOAD);
    assign bus.adc_start    = (state_q == S_START);
    assign bus.meas_valid   = (state_q == S_DONE);
    assign bus.dac_code     = dac_code_q;
    assign bus.meas_q       = meas_q_q;
    assign bus.meas_timeout = meas_to_q;

endmodule

// File: tb/tb_q_measure_seq.sv
// Bench for q_measure_seq: directed requests, an ADC responder model and a
// scoreboard monitor checking meas_q / meas_timeout / result cycle on every meas_valid.
// Works with and without Q_AVG_EN (expected values selected per build).
module tb_q_measure_seq;
    localparam int S     = 16;
    localparam int TO    = 8;
    localparam int LIMIT = 200;
`ifdef Q_AVG_EN
    localparam int N = 4;
`else
    localparam int N = 1;
`endif

    localparam int M_NORM  = 0;
    localparam int M_BUSY  = 1;
    localparam int M_B2B   = 2;
    localparam int M_STRAY = 3;

    typedef struct {
        logic [9:0] q;
        logic       to;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   last_done;

    exp_t       sb[$];
    logic [9:0] adc_q[$];
    int         adc_lat;
    int         pend;
    logic       resp_done;
    logic [9:0] resp_data;
    logic       stray_done;
    logic [9:0] stray_data;

    q_measure_seq_if #(.WIDTH(10)) bus ();

    assign bus.adc_done = resp_done | stray_done;
    assign bus.adc_data = resp_done ? resp_data : stray_data;

    q_measure_seq #(
        .WIDTH         (10),
        .SETTLE_CYCLES (S),
        .AVG_LOG2      (2),
        .TIMEOUT       (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: responds adc_lat cycles after seeing adc_start; adc_lat=0 never responds.
    initial begin
        resp_done = 1'b0;
        resp_data = '0;
        pend      = 0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    resp_done = 1'b1;
                    resp_data = (adc_q.size() != 0) ? adc_q.pop_front() : 10'd0;
                end
            end
            if (bus.adc_start && adc_lat > 0) pend = adc_lat;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.meas_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_meas_valid: got meas_q=%0d with no request outstanding (cycle %0d)",
                         bus.meas_q, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("meas_q", bus.meas_q, e.q);
                chk("meas_timeout", bus.meas_timeout, e.to);
                chk("result_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; issues one request and follows it to meas_valid.
    task automatic do_req(input logic [9:0] ref_v, input int s0, input int s1, input int s2,
                          input int s3, input logic [9:0] exp_q, input logic exp_to, input int mode);
        int   k;
        int   n;
        int   h;
        exp_t e;
        adc_q.delete();
        adc_q.push_back(10'(s0));
        adc_q.push_back(10'(s1));
        adc_q.push_back(10'(s2));
        adc_q.push_back(10'(s3));
        bus.req_valid = 1'b1;
        bus.i_ref     = ref_v;
        n = 0;
        while (!bus.req_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", bus.req_ready, 1);
        h = cyc;
        if (mode == M_B2B) chk("b2b_accept_cycle", h, last_done + 1);
        e.q   = exp_q;
        e.to  = exp_to;
        e.cyc = h + ((adc_lat == 0) ? (S + 3 + TO) : (S + 2 + N * (1 + adc_lat)));
        sb.push_back(e);

        @(negedge clk);
        k = 1;
        bus.req_valid = 1'b0;
        chk("dac_code", bus.dac_code, ref_v);
        chk("dac_load", bus.dac_load, 1);
        while (!bus.meas_valid && k < LIMIT) begin
            @(negedge clk);
            k++;
            stray_done = (mode == M_STRAY) && (k == 5 || k == S + 2);
            if (k == S + 2) chk("adc_start", bus.adc_start, 1);
            if (mode == M_BUSY && k == 4) begin
                bus.req_valid = 1'b1;
                bus.i_ref     = 10'd7;
                chk("busy_req_ready", bus.req_ready, 0);
            end
            if (mode == M_BUSY && k == 6) chk("busy_dac_code", bus.dac_code, ref_v);
        end
        stray_done = 1'b0;
        chk("meas_valid_seen", bus.meas_valid, 1);
        last_done = cyc;
        if (mode != M_BUSY) begin
            @(negedge clk);
            chk("meas_q_hold", bus.meas_q, exp_q);
            chk("ready_after_done", bus.req_ready, 1);
        end
    endtask

    initial begin
        int n;
        total         = 0;
        bad           = 0;
        last_done     = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.i_ref     = '0;
        stray_done    = 1'b0;
        stray_data    = 10'd999;
        adc_lat       = 1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_dac_code", bus.dac_code, 0);
        chk("rst_dac_load", bus.dac_load, 0);
        chk("rst_adc_start", bus.adc_start, 0);
        chk("rst_meas_valid", bus.meas_valid, 0);
        chk("rst_meas_q", bus.meas_q, 0);
        chk("rst_meas_timeout", bus.meas_timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic single/average cases.
        do_req(10'd512, 300, 300, 300, 300, 10'd300, 1'b0, M_NORM);
`ifdef Q_AVG_EN
        do_req(10'd513, 100, 101, 102, 103, 10'd101, 1'b0, M_NORM);
`else
        do_req(10'd513, 100, 101, 102, 103, 10'd100, 1'b0, M_NORM);
`endif
        do_req(10'd1023, 1023, 1023, 1023, 1023, 10'd1023, 1'b0, M_NORM);

        // Slow ADC: two extra WAIT cycles per sample.
        adc_lat = 3;
`ifdef Q_AVG_EN
        do_req(10'd20, 5, 6, 7, 9, 10'd6, 1'b0, M_NORM);
`else
        do_req(10'd20, 5, 6, 7, 9, 10'd5, 1'b0, M_NORM);
`endif

        // Timeout, then a good request clears the flag.
        adc_lat = 0;
        do_req(10'd30, 0, 0, 0, 0, 10'd0, 1'b1, M_NORM);
        adc_lat = 1;
        do_req(10'd40, 200, 200, 200, 200, 10'd200, 1'b0, M_NORM);

        // Request held while busy, accepted the cycle after DONE.
        do_req(10'd512, 40, 40, 40, 40, 10'd40, 1'b0, M_BUSY);
        do_req(10'd7, 41, 41, 41, 41, 10'd41, 1'b0, M_B2B);

        // Stray adc_done in SETTLE and START carrying data 999.
`ifdef Q_AVG_EN
        do_req(10'd60, 60, 61, 62, 63, 10'd61, 1'b0, M_STRAY);
`else
        do_req(10'd60, 60, 61, 62, 63, 10'd60, 1'b0, M_STRAY);
`endif

        // Reset in the middle of SETTLE.
        bus.req_valid = 1'b1;
        bus.i_ref     = 10'd99;
        n = 0;
        while (!bus.req_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", bus.req_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_dac_code", bus.dac_code, 0);
        chk("abort_meas_q", bus.meas_q, 0);
        chk("abort_meas_valid", bus.meas_valid, 0);
        chk("abort_adc_start", bus.adc_start, 0);
        chk("abort_dac_load", bus.dac_load, 0);
        chk("abort_meas_timeout", bus.meas_timeout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", bus.req_ready, 1);
        for (int i = 0; i < S + 8; i++) begin
            @(negedge clk);
            chk("abort_no_meas_valid", bus.meas_valid, 0);
        end
        do_req(10'd100, 77, 77, 77, 77, 10'd77, 1'b0, M_NORM);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
